// File: rtl/pipe_cmp_pkg.sv
// Shared status encoding and chunk-compare helper for the chunked pipelined comparator.
package pipe_cmp_pkg;

   typedef logic [1:0] status_t;

   localparam status_t ST_EQ = 2'b00;
   localparam status_t ST_GT = 2'b01;
   localparam status_t ST_LT = 2'b10;

   // Chunks are extended to this width by the caller before comparison.
   localparam int CMP_MAX_W = 64;

   function automatic status_t cmp_chunk(
      input logic [CMP_MAX_W-1:0] a,
      input logic [CMP_MAX_W-1:0] b,
      input logic                 is_signed
   );
      status_t st;
      st = ST_EQ;
      if (is_signed) begin
         if ($signed(a) < $signed(b))      st = ST_LT;
         else if ($signed(a) > $signed(b)) st = ST_GT;
      end else begin
         if (a < b)      st = ST_LT;
         else if (a > b) st = ST_GT;
      end
      return st;
   endfunction

endpackage

// File: rtl/pipe_cmp_stage.sv
// One comparator stage: compares the top CHUNK_W bits of the remaining operands and
// registers the verdict together with the still-uncompared lower bits.
module pipe_cmp_stage
   import pipe_cmp_pkg::*;
#(
   parameter int  REM_W   = 16,
   parameter int  CHUNK_W = 8,
   parameter bit  FIRST   = 1'b1,
   localparam int OUT_W   = (REM_W > CHUNK_W) ? (REM_W - CHUNK_W) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_valid,
   input  status_t          i_status,
   input  logic             i_signed,
   input  logic [REM_W-1:0] i_a,
   input  logic [REM_W-1:0] i_b,
   output logic             o_valid,
   output status_t          o_status,
   output logic             o_signed,
   output logic [OUT_W-1:0] o_a,
   output logic [OUT_W-1:0] o_b
);

   logic [CHUNK_W-1:0]   w_a_chunk;
   logic [CHUNK_W-1:0]   w_b_chunk;
   logic                 w_cmp_signed;
   logic [CMP_MAX_W-1:0] w_a_ext;
   logic [CMP_MAX_W-1:0] w_b_ext;
   status_t              w_status_next;

   logic                 r_valid;
   status_t              r_status;
   logic                 r_signed;

   assign w_a_chunk    = i_a[REM_W-1 -: CHUNK_W];
   assign w_b_chunk    = i_b[REM_W-1 -: CHUNK_W];
   assign w_cmp_signed = FIRST & i_signed;

   // Only the MSB chunk carries the sign bit, so only it is ever sign-extended.
   assign w_a_ext = {{(CMP_MAX_W-CHUNK_W){w_cmp_signed & w_a_chunk[CHUNK_W-1]}}, w_a_chunk};
   assign w_b_ext = {{(CMP_MAX_W-CHUNK_W){w_cmp_signed & w_b_chunk[CHUNK_W-1]}}, w_b_chunk};

   assign w_status_next = (i_status == ST_EQ) ? cmp_chunk(w_a_ext, w_b_ext, w_cmp_signed)
                                              : i_status;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid  <= 1'b0;
         r_status <= ST_EQ;
         r_signed <= 1'b0;
      end else if (i_en) begin
         r_valid  <= i_valid;
         r_status <= w_status_next;
         r_signed <= i_signed;
      end
   end

   assign o_valid  = r_valid;
   assign o_status = r_status;
   assign o_signed = r_signed;

   if (REM_W > CHUNK_W) begin : g_rest
      logic [OUT_W-1:0] r_a;
      logic [OUT_W-1:0] r_b;

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_a <= '0;
            r_b <= '0;
         end else if (i_en) begin
            r_a <= i_a[OUT_W-1:0];
            r_b <= i_b[OUT_W-1:0];
         end
      end

      assign o_a = r_a;
      assign o_b = r_b;
   end else begin : g_last
      assign o_a = '0;
      assign o_b = '0;
   end

endmodule

// File: rtl/pipe_cmp_chunked.sv
// Pipelined chunked magnitude comparator (MSB chunk first) with valid/ready flow control.
// Define PIPE_CMP_TAG_EN to carry a sideband tag (tag_i/tag_o) alongside each transaction.
module pipe_cmp_chunked
   import pipe_cmp_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int CHUNK_W = 8,
   parameter int TAG_W   = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] A_i,
   input  logic [DATA_W-1:0] B_i,
   input  logic              signed_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              lt_o,
   output logic              eq_o,
   output logic              gt_o
`ifdef PIPE_CMP_TAG_EN
   ,
   input  logic [TAG_W-1:0]  tag_i,
   output logic [TAG_W-1:0]  tag_o
`endif
);

   localparam int STAGES = DATA_W / CHUNK_W;
   localparam int LAST   = STAGES - 1;

   if ((CHUNK_W < 1) || (CHUNK_W >= CMP_MAX_W) || (DATA_W < CHUNK_W) ||
       ((DATA_W % CHUNK_W) != 0) || (TAG_W < 1)) begin : g_param_check
      $error("pipe_cmp_chunked: DATA_W must be a non-zero multiple of CHUNK_W");
   end

   logic [STAGES-1:0] w_vld;
   logic [STAGES:0]   w_en;
   status_t           w_st_last;
   logic              w_unused;

   // A stage may load when it is empty or when the stage after it is also moving.
   always_comb begin
      w_en         = '0;
      w_en[STAGES] = ready_i;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_en[k] = ~w_vld[k] | w_en[k+1];
      end
   end

   assign ready_o = w_en[0];

   genvar gi;
   for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int REM_W = DATA_W - gi * CHUNK_W;
      localparam int OUT_W = (REM_W > CHUNK_W) ? (REM_W - CHUNK_W) : 1;

      logic             w_v_in;
      status_t          w_st_in;
      logic             w_sgn_in;
      logic [REM_W-1:0] w_a_in;
      logic [REM_W-1:0] w_b_in;
      status_t          w_st;
      logic             w_sgn;
      logic [OUT_W-1:0] w_a;
      logic [OUT_W-1:0] w_b;

      if (gi == 0) begin : g_head
         assign w_v_in   = valid_i;
         assign w_st_in  = ST_EQ;
         assign w_sgn_in = signed_i;
         assign w_a_in   = A_i;
         assign w_b_in   = B_i;
      end else begin : g_body
         assign w_v_in   = w_vld[gi-1];
         assign w_st_in  = g_stage[gi-1].w_st;
         assign w_sgn_in = g_stage[gi-1].w_sgn;
         assign w_a_in   = g_stage[gi-1].w_a;
         assign w_b_in   = g_stage[gi-1].w_b;
      end

      pipe_cmp_stage #(
         .REM_W   (REM_W),
         .CHUNK_W (CHUNK_W),
         .FIRST   (gi == 0)
      ) u_stage (
         .i_clk    (clk_i),
         .i_rst    (rst_i),
         .i_en     (w_en[gi]),
         .i_valid  (w_v_in),
         .i_status (w_st_in),
         .i_signed (w_sgn_in),
         .i_a      (w_a_in),
         .i_b      (w_b_in),
         .o_valid  (w_vld[gi]),
         .o_status (w_st),
         .o_signed (w_sgn),
         .o_a      (w_a),
         .o_b      (w_b)
      );

`ifdef PIPE_CMP_TAG_EN
      logic [TAG_W-1:0] w_tag_in;
      logic [TAG_W-1:0] r_tag;

      if (gi == 0) begin : g_tag_head
         assign w_tag_in = tag_i;
      end else begin : g_tag_body
         assign w_tag_in = g_stage[gi-1].r_tag;
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i)         r_tag <= '0;
         else if (w_en[gi]) r_tag <= w_tag_in;
      end
`endif
   end

   assign valid_o   = w_vld[LAST];
   assign w_st_last = g_stage[LAST].w_st;

   assign lt_o = valid_o & (w_st_last == ST_LT);
   assign gt_o = valid_o & (w_st_last == ST_GT);
   assign eq_o = valid_o & (w_st_last == ST_EQ);

`ifdef PIPE_CMP_TAG_EN
   assign tag_o = g_stage[LAST].r_tag;
`endif

   // The last stage has no lower bits left and its signed flag has no consumer.
   assign w_unused = ^{g_stage[LAST].w_a, g_stage[LAST].w_b, g_stage[LAST].w_sgn};

endmodule

// File: tb/tb_pipe_cmp_chunked.sv
// Bench for pipe_cmp_chunked: a 16/8 and a 32/8 instance checked against a scoreboard model.
module tb_pipe_cmp_chunked;

   localparam logic [2:0] R_LT = 3'b100;
   localparam logic [2:0] R_EQ = 3'b010;
   localparam logic [2:0] R_GT = 3'b001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        vin [2];
   logic        rdy_in [2];
   logic        sgn_in [2];
   logic [31:0] a_in [2];
   logic [31:0] b_in [2];
   logic        vout [2];
   logic        rdy_out [2];
   logic        lt [2];
   logic        eq [2];
   logic        gt [2];
`ifdef PIPE_CMP_TAG_EN
   logic [3:0]  tag_in [2];
   logic [3:0]  tag_out [2];
   logic [3:0]  sb_tag [2][256];
`endif

   int          n_asserts = 0;
   int          n_fail = 0;
   int          cyc = 0;
   bit          stall_en = 1'b0;
   logic [2:0]  sb_res [2][256];
   int          sb_wr [2];
   int          sb_rd [2];
   int          next_tag [2];
   bit          prev_stall [2];
   logic [6:0]  prev_obs [2];
   logic [6:0]  obs_m;

   pipe_cmp_chunked #(.DATA_W(16), .CHUNK_W(8), .TAG_W(4)) u_dut16 (
      .clk_i(clk), .rst_i(rst), .valid_i(vin[0]), .ready_o(rdy_out[0]),
      .A_i(a_in[0][15:0]), .B_i(b_in[0][15:0]), .signed_i(sgn_in[0]),
      .valid_o(vout[0]), .ready_i(rdy_in[0]), .lt_o(lt[0]), .eq_o(eq[0]), .gt_o(gt[0])
`ifdef PIPE_CMP_TAG_EN
      , .tag_i(tag_in[0]), .tag_o(tag_out[0])
`endif
   );

   pipe_cmp_chunked #(.DATA_W(32), .CHUNK_W(8), .TAG_W(4)) u_dut32 (
      .clk_i(clk), .rst_i(rst), .valid_i(vin[1]), .ready_o(rdy_out[1]),
      .A_i(a_in[1]), .B_i(b_in[1]), .signed_i(sgn_in[1]),
      .valid_o(vout[1]), .ready_i(rdy_in[1]), .lt_o(lt[1]), .eq_o(eq[1]), .gt_o(gt[1])
`ifdef PIPE_CMP_TAG_EN
      , .tag_i(tag_in[1]), .tag_o(tag_out[1])
`endif
   );

   function automatic int width_of(int d);
      return (d == 0) ? 16 : 32;
   endfunction

   function automatic logic [31:0] mask_of(int d);
      return (d == 0) ? 32'h0000FFFF : 32'hFFFFFFFF;
   endfunction

   // Reference: interpret the operands as integers and compare them directly.
   function automatic logic [2:0] ref_cmp(logic [31:0] a, logic [31:0] b, logic s, int w);
      longint sa;
      longint sb;
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
      if (s && a[w-1]) sa = sa - (longint'(1) << w);
      if (s && b[w-1]) sb = sb - (longint'(1) << w);
      return {sa < sb, sa == sb, sa > sb};
   endfunction

   function automatic logic [3:0] tag_of(int d);
`ifdef PIPE_CMP_TAG_EN
      return tag_out[d];
`else
      return 4'd0 + 4'(d & 0);
`endif
   endfunction

   task automatic chk(input int d, input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL dut%0d %s: observed=%0h expected=%0h", d, name, obs, exp);
      end
   endtask

   task automatic send(input int d, input logic [31:0] a, input logic [31:0] b, input logic s);
      vin[d]    = 1'b1;
      a_in[d]   = a & mask_of(d);
      b_in[d]   = b & mask_of(d);
      sgn_in[d] = s;
`ifdef PIPE_CMP_TAG_EN
      tag_in[d] = next_tag[d][3:0];
`endif
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rdy_out[d]) begin
            sb_res[d][sb_wr[d] % 256] = ref_cmp(a & mask_of(d), b & mask_of(d), s, width_of(d));
`ifdef PIPE_CMP_TAG_EN
            sb_tag[d][sb_wr[d] % 256] = next_tag[d][3:0];
`endif
            sb_wr[d]++;
            next_tag[d]++;
            @(posedge clk);
            #1;
            vin[d] = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      chk(d, "send_timeout_ready", 64'(rdy_out[d]), 64'd1);
      vin[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      for (int i = 0; i < 400; i++) begin
         if (sb_rd[d] == sb_wr[d]) break;
         @(posedge clk);
         #1;
      end
      chk(d, "drain_pending", 64'(sb_wr[d] - sb_rd[d]), 64'd0);
   endtask

   task automatic lat_check(input int d, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [2:0] exp, input int lat);
      drain(d);
      rdy_in[d] = 1'b1;
      send(d, a, b, s);
      for (int i = 1; i < lat; i++) begin
         chk(d, "latency_early_valid", 64'(vout[d]), 64'd0);
         @(posedge clk);
         #1;
      end
      chk(d, "latency_valid", 64'(vout[d]), 64'd1);
      chk(d, "latency_result", 64'({lt[d], eq[d], gt[d]}), 64'(exp));
   endtask

   task automatic rand_op(input int d);
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom & mask_of(d);
      case ($urandom_range(0, 3))
         0:       b = a;
         1:       b = a ^ ($urandom & 32'h000000FF);
         2:       b = a ^ (32'h1 << (width_of(d) - 1));
         default: b = $urandom;
      endcase
      send(d, a, b, 1'($urandom_range(0, 1)));
   endtask

   always @(posedge clk) begin
      cyc++;
      if (stall_en) begin
         #1;
         rdy_in[0] = ($urandom_range(0, 3) != 0);
         rdy_in[1] = ($urandom_range(0, 3) != 0);
      end
   end

   // Output monitor: scoreboard pop on each transfer, hold check while stalled, idle flags.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall[0] = 1'b0;
         prev_stall[1] = 1'b0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            obs_m = {tag_of(d), lt[d], eq[d], gt[d]};
            if (prev_stall[d]) chk(d, "stall_hold", 64'(obs_m), 64'(prev_obs[d]));
            if (vout[d]) begin
               if (rdy_in[d]) begin
                  chk(d, "scoreboard_nonempty", 64'(sb_wr[d] != sb_rd[d]), 64'd1);
                  if (sb_wr[d] != sb_rd[d]) begin
                     chk(d, "result", 64'(obs_m[2:0]), 64'(sb_res[d][sb_rd[d] % 256]));
`ifdef PIPE_CMP_TAG_EN
                     chk(d, "tag", 64'(obs_m[6:3]), 64'(sb_tag[d][sb_rd[d] % 256]));
`endif
                     sb_rd[d]++;
                  end
               end
            end else begin
               chk(d, "idle_flags", 64'(obs_m[2:0]), 64'd0);
            end
            prev_stall[d] = vout[d] & ~rdy_in[d];
            prev_obs[d]   = obs_m;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] c0;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         vin[d] = 1'b0; rdy_in[d] = 1'b1; sgn_in[d] = 1'b0;
         a_in[d] = '0; b_in[d] = '0;
         sb_wr[d] = 0; sb_rd[d] = 0; next_tag[d] = 0;
`ifdef PIPE_CMP_TAG_EN
         tag_in[d] = '0;
`endif
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk(d, "reset_valid", 64'(vout[d]), 64'd0);
         chk(d, "reset_flags", 64'({lt[d], eq[d], gt[d]}), 64'd0);
      end
      rst = 1'b0;

      // Directed compares from the datapath's point of view.
      lat_check(0, 32'h1280, 32'h12FF, 1'b0, R_LT, 2);
      lat_check(0, 32'h1300, 32'h12FF, 1'b0, R_GT, 2);
      lat_check(0, 32'hABCD, 32'hABCD, 1'b0, R_EQ, 2);
      lat_check(0, 32'h8000, 32'h0001, 1'b1, R_LT, 2);
      lat_check(0, 32'h8000, 32'h0001, 1'b0, R_GT, 2);
      lat_check(1, 32'h01020304, 32'h01020305, 1'b0, R_LT, 4);
      lat_check(1, 32'h80000000, 32'h00000001, 1'b1, R_LT, 4);
      lat_check(1, 32'h80000000, 32'h00000001, 1'b0, R_GT, 4);

      // Backpressure: the 2-deep pipe fills, blocks, then flows through with no bubble.
      drain(0);
      rdy_in[0] = 1'b0;
      rand_op(0);
      rand_op(0);
      chk(0, "bp_ready_low_when_full", 64'(rdy_out[0]), 64'd0);
      chk(0, "bp_valid_held", 64'(vout[0]), 64'd1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rdy_in[0] = 1'b1;
      #1;
      chk(0, "bp_ready_follows_downstream", 64'(rdy_out[0]), 64'd1);
      repeat (3) rand_op(0);
      drain(0);

      // Full-rate random streams: one accept per cycle.
      for (int d = 0; d < 2; d++) begin
         drain(d);
         rdy_in[d] = 1'b1;
         c0 = cyc;
         repeat (200) rand_op(d);
         chk(d, "full_rate_cycles", 64'(cyc - c0), 64'd200);
         drain(d);
      end

      // Random downstream stalls; tags cycle 0..F with each transaction.
      stall_en = 1'b1;
      for (int d = 0; d < 2; d++) repeat (48) rand_op(d);
      stall_en = 1'b0;
      @(posedge clk);
      #1;
      rdy_in[0] = 1'b1;
      rdy_in[1] = 1'b1;
      drain(0);
      drain(1);

      // Reset mid-stream: in-flight work is discarded and nothing emerges afterwards.
      rdy_in[0] = 1'b0;
      rand_op(0);
      rand_op(0);
      rand_op(1);
      rand_op(1);
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk(d, "midrst_valid", 64'(vout[d]), 64'd0);
         chk(d, "midrst_flags", 64'({lt[d], eq[d], gt[d]}), 64'd0);
         sb_rd[d] = sb_wr[d];
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      rdy_in[0] = 1'b1;
      rdy_in[1] = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
         chk(0, "post_reset_idle", 64'(vout[0]), 64'd0);
         chk(1, "post_reset_idle", 64'(vout[1]), 64'd0);
      end
      lat_check(0, 32'h0001, 32'h0002, 1'b0, R_LT, 2);
      lat_check(1, 32'hFFFFFFFF, 32'h00000000, 1'b1, R_LT, 4);
      drain(0);
      drain(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
